// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the multiply-accumulate datapath.
//   rnd_mode_e : rounding modes for the final Q-format conversion
//                (RND_FLOOR, RND_HALF_UP, RND_HALF_AWAY).
//   sat_limit  : largest or smallest value of a signed field of a given width.
//                Used for the saturation thresholds.
package mac_pkg;

  typedef enum int {
    RND_FLOOR     = 0,  // truncate toward -inf
    RND_HALF_UP   = 1,  // ties go toward +inf
    RND_HALF_AWAY = 2   // ties go away from zero
  } rnd_mode_e;

  // Signed limits of a 'width'-bit two's complement field (width <= 63).
  function automatic longint sat_limit(input int width, input bit want_max);
    longint mag;
    mag = longint'(1) << (width - 1);
    return want_max ? (mag - 1) : -mag;
  endfunction

endpackage

// File: rtl/rnd_sat.sv
// rnd_sat: combinational rounding and saturation of a full-precision signed sum.
// The sum carries FRAC_W fractional bits. The result is an OUT_W-bit signed integer.
//   sum   in  IN_W   full-precision signed sum
//   y_sat out OUT_W  rounded and clamped result
//   sat   out 1      result was clamped to the max or min of OUT_W
module rnd_sat
  import mac_pkg::*;
#(
  parameter int IN_W     = 36,
  parameter int FRAC_W   = 9,
  parameter int OUT_W    = 16,
  parameter int RND_MODE = 1
) (
  input  logic signed [IN_W-1:0]  sum,
  output logic signed [OUT_W-1:0] y_sat,
  output logic                    sat
);

  // The quotient keeps one extra MSB so that the rounding bias cannot wrap.
  localparam int Q_W   = IN_W - FRAC_W + 1;
  // The comparison width covers both the quotient and the output range, plus a sign bit.
  localparam int CMP_W = ((Q_W > OUT_W) ? Q_W : OUT_W) + 1;

  localparam logic [IN_W:0] ONE     = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0] HALF    = ONE << (FRAC_W - 1);
  localparam logic [IN_W:0] HALF_M1 = HALF - ONE;

  localparam logic signed [CMP_W-1:0] MAX_C = CMP_W'(sat_limit(OUT_W, 1'b1));
  localparam logic signed [CMP_W-1:0] MIN_C = CMP_W'(sat_limit(OUT_W, 1'b0));

  logic signed [IN_W:0]    ext;
  logic        [IN_W:0]    bias;
  logic signed [IN_W:0]    biased;
  logic signed [Q_W-1:0]   q;
  logic signed [CMP_W-1:0] q_ext;
  logic                    unused_frac;

  always_comb begin
    ext  = {sum[IN_W-1], sum};
    bias = '0;
    if (RND_MODE == int'(RND_HALF_UP)) begin
      bias = HALF;
    end else if (RND_MODE == int'(RND_HALF_AWAY)) begin
      // A negative tie must stay on the more negative side,
      // so the bias is one LSB short of a half.
      bias = sum[IN_W-1] ? HALF_M1 : HALF;
    end
    biased = ext + $signed(bias);
    // Dropping the low FRAC_W bits is the arithmetic shift right by FRAC_W.
    q      = biased[IN_W:FRAC_W];
    q_ext  = CMP_W'(q);

    y_sat = q_ext[OUT_W-1:0];
    sat   = 1'b0;
    if (q_ext > MAX_C) begin
      y_sat = MAX_C[OUT_W-1:0];
      sat   = 1'b1;
    end else if (q_ext < MIN_C) begin
      y_sat = MIN_C[OUT_W-1:0];
      sat   = 1'b1;
    end
  end

  // The discarded fraction bits are not used.
  assign unused_frac = ^biased[FRAC_W-1:0];

endmodule

// File: rtl/mac_acc_rnd_sat.sv
// mac_acc_rnd_sat: streaming signed multiply-accumulate over framed bursts.
// The last beat of a burst produces two results:
//   - the full-precision sum,
//   - a rounded, saturated Q-format result (FRAC_W fractional bits dropped).
// The pipeline has two stages: stage 1 registers the product, and stage 2
// accumulates and loads the output register.
// One global enable stalls every stage while a result is waiting for the consumer.
//   clk_i, rst_ni        clock, synchronous active-low reset
//   s_valid_i/s_ready_o  input beat handshake (a_i, x_i, first_i, last_i)
//   m_valid_o/m_ready_i  result handshake (y_sat_o, y_acc_o, sat_o, len_err_o)
//   sat_o                y_sat_o was clamped
//   len_err_o            burst had more than ACC_LEN terms (sum may have wrapped)
module mac_acc_rnd_sat
  import mac_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 9,
  parameter int ACC_LEN  = 16,
  parameter int ACC_W    = 2 * DATA_W + $clog2(ACC_LEN),
  parameter int RND_MODE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic                     first_i,
  input  logic                     last_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic signed [DATA_W-1:0] y_sat_o,
  output logic signed [ACC_W-1:0]  y_acc_o,
  output logic                     sat_o,
  output logic                     len_err_o
);

  localparam int PROD_W = 2 * DATA_W;
  // The counter must hold ACC_LEN+1, which is its saturation value.
  localparam int CNT_W  = $clog2(ACC_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_LEN + 1);

  // Stage 1: registered product and framing flags
  logic                     s1_valid_reg;
  logic                     s1_first_reg;
  logic                     s1_last_reg;
  logic signed [PROD_W-1:0] s1_prod_reg;

  // Stage 2: running sum and term count of the open burst
  logic signed [ACC_W-1:0]  acc_reg;
  logic        [CNT_W-1:0]  cnt_reg;

  // Output register
  logic                     out_valid_reg;
  logic signed [DATA_W-1:0] y_sat_reg;
  logic signed [ACC_W-1:0]  y_acc_reg;
  logic                     sat_reg;
  logic                     len_err_reg;

  logic                     en;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic        [CNT_W-1:0]  cnt_base;
  logic        [CNT_W-1:0]  cnt_next;
  logic                     len_err_next;
  logic signed [DATA_W-1:0] y_sat_next;
  logic                     sat_next;

  always_comb begin
    // Every stage advances unless a result is waiting and the consumer is not taking it.
    en       = !out_valid_reg || m_ready_i;

    acc_base = s1_first_reg ? '0 : acc_reg;
    prod_ext = ACC_W'(s1_prod_reg);
    acc_next = acc_base + prod_ext;

    cnt_base = s1_first_reg ? '0 : cnt_reg;
    cnt_next = (cnt_base == CNT_MAX) ? CNT_MAX : (cnt_base + CNT_ONE);
    len_err_next = (cnt_next > CNT_LIM);
  end

  // Rounding acts on acc_next, so the rounded value and the full sum
  // load into the output register in the same cycle.
  rnd_sat #(
    .IN_W     (ACC_W),
    .FRAC_W   (FRAC_W),
    .OUT_W    (DATA_W),
    .RND_MODE (RND_MODE)
  ) u_rnd_sat (
    .sum   (acc_next),
    .y_sat (y_sat_next),
    .sat   (sat_next)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_prod_reg   <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      y_sat_reg     <= '0;
      y_acc_reg     <= '0;
      sat_reg       <= 1'b0;
      len_err_reg   <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= s_valid_i;
      if (s_valid_i) begin
        s1_prod_reg  <= PROD_W'(a_i) * PROD_W'(x_i);
        s1_first_reg <= first_i;
        s1_last_reg  <= last_i;
      end

      // On a handshake with no new result, the valid clears. A new result in the same cycle sets it again.
      out_valid_reg <= s1_valid_reg && s1_last_reg;

      if (s1_valid_reg) begin
        if (s1_last_reg) begin
          // Closing a burst returns the accumulator to zero. A stray non-first
          // beat that follows then starts from an empty sum.
          acc_reg     <= '0;
          cnt_reg     <= '0;
          y_acc_reg   <= acc_next;
          y_sat_reg   <= y_sat_next;
          sat_reg     <= sat_next;
          len_err_reg <= len_err_next;
        end else begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_next;
        end
      end
    end
  end

  assign s_ready_o = en;
  assign m_valid_o = out_valid_reg;
  assign y_sat_o   = y_sat_reg;
  assign y_acc_o   = y_acc_reg;
  assign sat_o     = sat_reg;
  assign len_err_o = len_err_reg;

endmodule

// File: tb/tb_mac_acc_rnd_sat.sv
// Directed bench for mac_acc_rnd_sat.
// Three instances share all inputs and differ only in rounding mode (0, 1, 2).
// Each test task checks its own results inline against hand-computed values.
module tb_mac_acc_rnd_sat;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic                     s_valid;
  logic                     first;
  logic                     last;
  logic                     m_ready;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] x;
  logic [2:0]               s_ready;
  logic [2:0]               m_valid;
  logic [2:0]               sat;
  logic [2:0]               len_err;
  logic signed [DATA_W-1:0] y_sat [3];
  logic signed [ACC_W-1:0]  y_acc [3];

  int errors = 0;
  int checks = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mac_acc_rnd_sat #(
        .DATA_W   (DATA_W),
        .FRAC_W   (9),
        .ACC_LEN  (16),
        .RND_MODE (gi)
      ) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready[gi]),
        .a_i       (a),
        .x_i       (x),
        .first_i   (first),
        .last_i    (last),
        .m_valid_o (m_valid[gi]),
        .m_ready_i (m_ready),
        .y_sat_o   (y_sat[gi]),
        .y_acc_o   (y_acc[gi]),
        .sat_o     (sat[gi]),
        .len_err_o (len_err[gi])
      );
    end
  endgenerate

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and waits (bounded) until it is accepted. 'waits' counts the stalled cycles.
  task automatic send(input logic signed [DATA_W-1:0] av, input logic signed [DATA_W-1:0] xv,
                      input logic f, input logic l, output int waits);
    a = av; x = xv; first = f; last = l; s_valid = 1'b1;
    waits = 0;
    while (!s_ready[0] && waits < 50) begin
      step();
      waits++;
    end
    step();
    s_valid = 1'b0; first = 1'b0; last = 1'b0;
    $display("beat a=%0d x=%0d first=%0b last=%0b waits=%0d", av, xv, f, l, waits);
  endtask

  task automatic show_result(input string name);
    $display("result %s: valid=%b acc=%0d y=%0d/%0d/%0d sat=%b len_err=%b",
             name, m_valid, y_acc[0], y_sat[0], y_sat[1], y_sat[2], sat, len_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; first = 1'b0; last = 1'b0; m_ready = 1'b1; a = '0; x = '0;
    step(); step();
    show_result("reset");
    checks++; if ({m_valid, sat, len_err} !== 9'b0) begin errors++;
      $display("FAIL reset_flags: got %b want %b", {m_valid, sat, len_err}, 9'b0); end
    checks++; if (y_acc[0] !== 36'sd0 || {y_sat[0], y_sat[1], y_sat[2]} !== 48'h0) begin errors++;
      $display("FAIL reset_data: got acc=%0d y=%h want 0", y_acc[0], {y_sat[0], y_sat[1], y_sat[2]}); end
    rst_n = 1'b1;
    step();
    checks++; if (s_ready !== 3'b111) begin errors++;
      $display("FAIL reset_ready: got %b want 111", s_ready); end
  endtask

  task automatic test_single();
    int w;
    send(16'sd3, 16'sd100, 1'b1, 1'b1, w);
    checks++; if (m_valid !== 3'b000) begin errors++;
      $display("FAIL single_latency1: got valid=%b want 000", m_valid); end
    step();
    show_result("single");
    checks++; if (m_valid !== 3'b111) begin errors++;
      $display("FAIL single_latency2: got valid=%b want 111", m_valid); end
    checks++; if (y_acc[0] !== 36'sd300) begin errors++;
      $display("FAIL single_acc: got %0d want 300", y_acc[0]); end
    checks++; if ({y_sat[0], y_sat[1], y_sat[2]} !== {16'h0000, 16'h0001, 16'h0001}) begin errors++;
      $display("FAIL single_ysat: got %h want 000000010001", {y_sat[0], y_sat[1], y_sat[2]}); end
    step();
    checks++; if (m_valid !== 3'b000) begin errors++;
      $display("FAIL single_clear: got valid=%b want 000", m_valid); end
  endtask

  task automatic test_back_to_back();
    int w;
    int total = 0;
    for (int i = 0; i < 4; i++) begin
      send(16'sd512, 16'sd256, i == 0, i == 3, w);
      total += w;
    end
    checks++; if (total !== 0) begin errors++;
      $display("FAIL b2b_bubbles: got %0d stalls want 0", total); end
    step();
    show_result("burst4");
    checks++; if (y_acc[0] !== 36'sd524288) begin errors++;
      $display("FAIL b2b_acc: got %0d want 524288", y_acc[0]); end
    checks++; if ({y_sat[0], y_sat[1], y_sat[2]} !== {3{16'd1024}}) begin errors++;
      $display("FAIL b2b_ysat: got %h want 1024 x3", {y_sat[0], y_sat[1], y_sat[2]}); end
    checks++; if ({m_valid, sat, len_err} !== {3'b111, 3'b000, 3'b000}) begin errors++;
      $display("FAIL b2b_flags: got %b want 111000000", {m_valid, sat, len_err}); end
    step();
  endtask

  task automatic test_saturation();
    int w;
    send(16'sd32767, 16'sd32767, 1'b1, 1'b1, w);
    step();
    show_result("sat_pos");
    checks++; if (y_acc[0] !== 36'sd1073676289) begin errors++;
      $display("FAIL satpos_acc: got %0d want 1073676289", y_acc[0]); end
    checks++; if ({y_sat[0], y_sat[1], y_sat[2]} !== {3{16'h7fff}} || sat !== 3'b111) begin errors++;
      $display("FAIL satpos_ysat: got y=%h sat=%b want 7fff x3 sat=111", {y_sat[0], y_sat[1], y_sat[2]}, sat); end
    send(-16'sd32768, 16'sd32767, 1'b1, 1'b1, w);
    step();
    show_result("sat_neg");
    checks++; if (y_acc[0] !== -36'sd1073709056) begin errors++;
      $display("FAIL satneg_acc: got %0d want -1073709056", y_acc[0]); end
    checks++; if ({y_sat[0], y_sat[1], y_sat[2]} !== {3{16'h8000}} || sat !== 3'b111) begin errors++;
      $display("FAIL satneg_ysat: got y=%h sat=%b want 8000 x3 sat=111", {y_sat[0], y_sat[1], y_sat[2]}, sat); end
    step();
  endtask

  task automatic test_ties();
    int w;
    send(16'sd1, 16'sd256, 1'b1, 1'b1, w);
    step();
    show_result("tie_pos");
    checks++; if (y_acc[0] !== 36'sd256 || {y_sat[0], y_sat[1], y_sat[2]} !== {16'h0000, 16'h0001, 16'h0001}) begin errors++;
      $display("FAIL tie_pos: got acc=%0d y=%h want 256 000000010001", y_acc[0], {y_sat[0], y_sat[1], y_sat[2]}); end
    send(-16'sd1, 16'sd256, 1'b1, 1'b1, w);
    step();
    show_result("tie_neg");
    checks++; if (y_acc[0] !== -36'sd256 || {y_sat[0], y_sat[1], y_sat[2]} !== {16'hffff, 16'h0000, 16'hffff}) begin errors++;
      $display("FAIL tie_neg: got acc=%0d y=%h want -256 ffff0000ffff", y_acc[0], {y_sat[0], y_sat[1], y_sat[2]}); end
    checks++; if (sat !== 3'b000) begin errors++;
      $display("FAIL tie_sat: got %b want 000", sat); end
    step();
  endtask

  task automatic test_backpressure();
    int w;
    m_ready = 1'b0;
    send(16'sd2, 16'sd512, 1'b1, 1'b1, w);
    send(16'sd4, 16'sd512, 1'b1, 1'b1, w);
    checks++; if (w !== 0) begin errors++;
      $display("FAIL bp_second_accept: got %0d stalls want 0", w); end
    // A third beat is offered while the output is blocked.
    a = 16'sd6; x = 16'sd512; first = 1'b1; last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({s_ready, m_valid} !== 6'b000111 || y_sat[1] !== 16'sd2 || y_acc[0] !== 36'sd1024) begin errors++;
        $display("FAIL bp_hold%0d: got ready=%b valid=%b y=%0d acc=%0d want 000 111 2 1024",
                 i, s_ready, m_valid, y_sat[1], y_acc[0]); end
      step();
    end
    m_ready = 1'b1;
    step();
    s_valid = 1'b0; first = 1'b0; last = 1'b0;
    show_result("bp_second");
    checks++; if (m_valid !== 3'b111 || y_sat[1] !== 16'sd4 || y_acc[0] !== 36'sd2048) begin errors++;
      $display("FAIL bp_second: got valid=%b y=%0d acc=%0d want 111 4 2048", m_valid, y_sat[1], y_acc[0]); end
    step();
    show_result("bp_third");
    checks++; if (m_valid !== 3'b111 || y_sat[1] !== 16'sd6 || y_acc[0] !== 36'sd3072) begin errors++;
      $display("FAIL bp_third: got valid=%b y=%0d acc=%0d want 111 6 3072", m_valid, y_sat[1], y_acc[0]); end
    step();
    checks++; if (m_valid !== 3'b000) begin errors++;
      $display("FAIL bp_drain: got valid=%b want 000", m_valid); end
  endtask

  task automatic test_len_err();
    int w;
    for (int i = 0; i < 16; i++) send(16'sd1, 16'sd512, i == 0, i == 15, w);
    step();
    show_result("len16");
    checks++; if (y_acc[0] !== 36'sd8192 || y_sat[0] !== 16'sd16 || len_err !== 3'b000) begin errors++;
      $display("FAIL len16: got acc=%0d y=%0d len_err=%b want 8192 16 000", y_acc[0], y_sat[0], len_err); end
    for (int i = 0; i < 17; i++) send(16'sd1, 16'sd512, i == 0, i == 16, w);
    step();
    show_result("len17");
    checks++; if (y_acc[0] !== 36'sd8704 || y_sat[0] !== 16'sd17 || len_err !== 3'b111) begin errors++;
      $display("FAIL len17: got acc=%0d y=%0d len_err=%b want 8704 17 111", y_acc[0], y_sat[0], len_err); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    int w;
    m_ready = 1'b0;
    send(16'sd5, 16'sd512, 1'b1, 1'b1, w);
    send(16'sd7, 16'sd512, 1'b1, 1'b0, w);
    checks++; if (m_valid !== 3'b111) begin errors++;
      $display("FAIL mid_pending: got valid=%b want 111", m_valid); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    show_result("mid_reset");
    checks++; if (m_valid !== 3'b000 || y_acc[0] !== 36'sd0 || y_sat[0] !== 16'sd0 || s_ready !== 3'b111) begin errors++;
      $display("FAIL mid_reset: got valid=%b acc=%0d y=%0d ready=%b want 000 0 0 111",
               m_valid, y_acc[0], y_sat[0], s_ready); end
    // A non-first closing beat right after reset must sum from zero.
    send(16'sd1, 16'sd512, 1'b0, 1'b1, w);
    step();
    show_result("after_reset");
    checks++; if (m_valid !== 3'b111 || y_acc[0] !== 36'sd512 || y_sat[0] !== 16'sd1 || len_err !== 3'b000) begin errors++;
      $display("FAIL after_reset: got valid=%b acc=%0d y=%0d len_err=%b want 111 512 1 000",
               m_valid, y_acc[0], y_sat[0], len_err); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_ties();
    test_backpressure();
    test_len_err();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation timeout");
  end

endmodule
